vec_normalize: RTL and testbench
================================

Name: vec_normalize

Overview:
- Normalizes a signed Q16.16 3-vector (x, y, z) to unit length. Also reports the vector's magnitude.
- Sits directly downstream of ray/normal generation and upstream of intersection/shading math.
- Internally sequences one sqrt (WIDTH=32, FBITS=16) and one div (WIDTH=32, FBITS=16) instance.
- Flow: sum of squares → sqrt → three sequential divides by the magnitude.

Parameters:
- WIDTH, 32, component width in bits, signed fixed point; only 32 is supported.
- FBITS, 16, fractional bits in each component; only 16 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block idle and able to accept a vector
- x, y, z  in  32 each  signed Q16.16 components
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts the result
- nx, ny, nz  out  32 each  signed Q16.16 unit-vector components
- mag  out  32  unsigned Q16.16 magnitude
- zero_vec  out  1  input was (0,0,0)
- ovf  out  1  sum of squares saturated

Behaviour:
- Reset (synchronous, active-high):
  - in_ready=1, out_valid=0; nx, ny, nz, mag = 0; zero_vec=0, ovf=0; FSM goes to IDLE.
  - rst is also routed to the div instance.
  - rst mid-operation aborts the vector; the in-flight result is never emitted.
- Handshake:
  - A vector is accepted on a cycle where in_valid && in_ready.
  - in_ready=1 only in IDLE.
  - out_valid rises in DONE and stays high, with all outputs stable, until out_valid && out_ready. The FSM then returns to IDLE and in_ready=1 on the next cycle.
- Capture (accept cycle):
  - Register x, y, z.
  - Any component equal to 0x80000000 is clamped to 0x80000001, so div never sees its smallest-negative overflow case.
- States:
  - IDLE: wait for accept, then go to SQUARE.
  - SQUARE (1 cycle):
    - Each component is squared as a 64-bit signed product, shifted right 16, and summed in 48 bits unsigned.
    - If sum > 0xFFFFFFFF: rad=0xFFFFFFFF, ovf=1. Otherwise rad=sum[31:0], ovf=0.
    - If rad==0: zero_vec=1, nx=ny=nz=mag=0, go to DONE. No sqrt or div is started.
    - Otherwise go to SQRT_GO.
  - SQRT_GO: pulse sqrt start for 1 cycle, then go to SQRT_WAIT.
  - SQRT_WAIT:
    - sqrt valid is sampled only in this state. Stale valid from an earlier run is cleared by the start pulse before this state is entered.
    - On valid: mag <= root, then go to DIV_GO with k=0.
  - DIV_GO: pulse div start with a = component k and b = mag (mag < 2^31 always), then go to DIV_WAIT.
  - DIV_WAIT:
    - On div done && valid: store val into nx, ny or nz (selected by k).
    - If k<2: k++ and go to DIV_GO. Otherwise go to DONE.
    - On done with ovf or dbz (must not occur): store 0 for that component and set ovf=1.
  - DONE: out_valid=1; leave on the handshake.
- Latency:
  - Zero vector: accept to out_valid = 3 cycles.
  - Non-zero vector: ~25 cycles for sqrt plus 3 × ~51 cycles for div; the worst-case bound is 200 cycles.
  - Benches check by handshake, not by exact cycle.
- Precision:
  - mag is truncated (sqrt floor).
  - Components use div Gaussian rounding; tolerance is ±1 LSB against the real value.
  - Sign of each component is preserved; |n| ≤ 0x00010000 + 1 LSB.
- in_valid asserted while busy is ignored, not queued.
- out_ready asserted outside DONE has no effect.
- zero_vec and ovf are valid only while out_valid=1; they are cleared on the next accept.

Test Plan:
- (3.0, 4.0, 0) = (0x00030000, 0x00040000, 0) → mag=0x00050000, nx=0x0000999A±1, ny=0x0000CCCD±1, nz=0, zero_vec=0, ovf=0.
- (-2.0, 0, 0) → mag=0x00020000, nx=0xFFFF0000, ny=nz=0.
- (1.0, 1.0, 1.0) → mag=0x0001BB67, nx=ny=nz=0x000093CD±1.
- (0, 0, 0) → zero_vec=1, all outputs 0, out_valid exactly 3 cycles after accept.
- (300.0, 0, 0) → ovf=1, mag=0x00FFFFFF±1, result still produced.
- Backpressure and reset: hold out_ready=0 for 20 cycles; outputs must be stable and in_ready=0. Then assert rst in SQRT_WAIT of a new vector: out_valid=0 and in_ready=1 the next cycle. A following (3, 4, 0) vector then returns the correct result.

Source files
------------

// File: rtl/vec_normalize.sv
// vec_normalize: scales a signed Q16.16 3-vector to unit length and reports its magnitude.
// One shared integer sqrt and one shared Q16.16 divider are sequenced by a small FSM.

module vec_normalize_sqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_rad,
  output logic        o_valid,
  output logic [23:0] o_root
);
  // Root of (rad << 16) so the result stays Q16.16; one root bit per cycle, truncated.
  logic [47:0] r_rad;
  logic [25:0] r_rem;
  logic [23:0] r_root;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_valid;
  logic [27:0] w_rem_sh;
  logic [27:0] w_trial;
  logic        w_fit;

  assign w_rem_sh = {r_rem, r_rad[47:46]};
  assign w_trial  = {2'b00, r_root, 2'b01};
  assign w_fit    = (w_rem_sh >= w_trial);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_rad   <= {i_rad, 16'h0000};
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else if (r_busy) begin
      r_rad  <= {r_rad[45:0], 2'b00};
      r_rem  <= w_fit ? 26'(w_rem_sh - w_trial) : w_rem_sh[25:0];
      r_root <= {r_root[22:0], w_fit};
      if (r_cnt == 5'd23) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_root  = r_root;
endmodule

module vec_normalize_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic        o_valid,
  output logic        o_ovf,
  output logic        o_dbz,
  output logic [31:0] o_val
);
  // Signed Q16.16 a/b: restoring division of |a|<<16 by |b|, round-half-even, then sign.
  logic [47:0] r_dvd;
  logic [47:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_rnd;
  logic        r_done;
  logic        r_valid;
  logic        r_ovf;
  logic        r_dbz;
  logic [31:0] r_val;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_rem_sh;
  logic        w_fit;
  logic [31:0] w_sub;
  logic [33:0] w_twice;
  logic        w_up;
  logic [48:0] w_qr;
  logic        w_q_ovf;
  logic [31:0] w_val;

  assign w_a_abs  = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_b_abs  = i_b[31] ? (~i_b + 32'd1) : i_b;
  assign w_rem_sh = {r_rem, r_dvd[47]};
  assign w_fit    = (w_rem_sh >= {1'b0, r_div});
  assign w_sub    = w_rem_sh[31:0] - r_div;
  assign w_twice  = {1'b0, r_rem, 1'b0};
  assign w_up     = (w_twice > {2'b00, r_div}) || ((w_twice == {2'b00, r_div}) && r_quo[0]);
  assign w_qr     = {1'b0, r_quo} + {48'd0, w_up};
  assign w_q_ovf  = (w_qr > 49'h0_0000_7FFF_FFFF);
  assign w_val    = r_neg ? (~w_qr[31:0] + 32'd1) : w_qr[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_rnd   <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
      r_val   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_dvd   <= {w_a_abs, 16'h0000};
        r_div   <= w_b_abs;
        r_neg   <= i_a[31] ^ i_b[31];
        r_rem   <= '0;
        r_quo   <= '0;
        r_cnt   <= '0;
        r_rnd   <= 1'b0;
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
        r_dbz   <= 1'b0;
        if (i_b == 32'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dbz  <= 1'b1;
          r_val  <= '0;
        end else begin
          r_busy <= 1'b1;
        end
      end else if (r_busy) begin
        r_dvd <= {r_dvd[46:0], 1'b0};
        r_rem <= w_fit ? w_sub : w_rem_sh[31:0];
        r_quo <= {r_quo[46:0], w_fit};
        if (r_cnt == 6'd47) begin
          r_busy <= 1'b0;
          r_rnd  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end else if (r_rnd) begin
        r_rnd  <= 1'b0;
        r_done <= 1'b1;
        if (w_q_ovf) begin
          r_ovf <= 1'b1;
          r_val <= '0;
        end else begin
          r_valid <= 1'b1;
          r_val   <= w_val;
        end
      end
    end
  end

  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;
  assign o_dbz   = r_dbz;
  assign o_val   = r_val;
endmodule

module vec_normalize #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        nx,
  output logic [WIDTH-1:0]        ny,
  output logic [WIDTH-1:0]        nz,
  output logic [WIDTH-1:0]        mag,
  output logic                    zero_vec,
  output logic                    ovf,
  output logic [2:0]              o_dbg_state
);
  // Handshakes: a vector transfers on a cycle with in_valid && in_ready; a result transfers
  // on a cycle with out_valid && out_ready, and out_valid plus all outputs hold until then.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SQUARE    = 3'd1,
    S_SQRT_GO   = 3'd2,
    S_SQRT_WAIT = 3'd3,
    S_DIV_GO    = 3'd4,
    S_DIV_WAIT  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic signed [31:0] r_z;
  logic [31:0] r_rad;
  logic [1:0]  r_k;
  logic [31:0] r_mag;
  logic [31:0] r_nx;
  logic [31:0] r_ny;
  logic [31:0] r_nz;
  logic        r_zero;
  logic        r_ovf;
  logic        r_out_valid;

  logic        w_accept;
  logic        w_release;
  logic [31:0] w_cx;
  logic [31:0] w_cy;
  logic [31:0] w_cz;
  logic signed [63:0] w_sq_x;
  logic signed [63:0] w_sq_y;
  logic signed [63:0] w_sq_z;
  logic [47:0] w_sum;
  logic        w_sat;
  logic [31:0] w_rad;
  logic        w_sqrt_start;
  logic        w_sqrt_valid;
  logic [23:0] w_root;
  logic        w_div_start;
  logic [31:0] w_div_a;
  logic        w_div_done;
  logic        w_div_valid;
  logic        w_div_ovf;
  logic        w_div_dbz;
  logic [31:0] w_div_val;

  assign w_accept  = in_valid && in_ready;
  assign w_release = r_out_valid && out_ready;

  // The most negative value is nudged by one LSB so its magnitude fits in 31 bits.
  assign w_cx = (x == 32'h8000_0000) ? 32'h8000_0001 : x;
  assign w_cy = (y == 32'h8000_0000) ? 32'h8000_0001 : y;
  assign w_cz = (z == 32'h8000_0000) ? 32'h8000_0001 : z;

  assign w_sq_x = 64'(r_x) * 64'(r_x);
  assign w_sq_y = 64'(r_y) * 64'(r_y);
  assign w_sq_z = 64'(r_z) * 64'(r_z);
  assign w_sum  = 48'(w_sq_x >> FBITS) + 48'(w_sq_y >> FBITS) + 48'(w_sq_z >> FBITS);
  assign w_sat  = |w_sum[47:32];
  assign w_rad  = w_sat ? 32'hFFFF_FFFF : w_sum[31:0];

  assign w_div_a = (r_k == 2'd0) ? r_x : ((r_k == 2'd1) ? r_y : r_z);

  vec_normalize_sqrt u_sqrt (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_sqrt_start),
    .i_rad   (r_rad),
    .o_valid (w_sqrt_valid),
    .o_root  (w_root)
  );

  vec_normalize_div u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_div_start),
    .i_a     (w_div_a),
    .i_b     (r_mag),
    .o_done  (w_div_done),
    .o_valid (w_div_valid),
    .o_ovf   (w_div_ovf),
    .o_dbz   (w_div_dbz),
    .o_val   (w_div_val)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_SQUARE;
      S_SQUARE:    w_next = (w_rad == 32'd0) ? S_DONE : S_SQRT_GO;
      S_SQRT_GO:   w_next = S_SQRT_WAIT;
      S_SQRT_WAIT: if (w_sqrt_valid) w_next = S_DIV_GO;
      S_DIV_GO:    w_next = S_DIV_WAIT;
      S_DIV_WAIT:  if (w_div_done) w_next = (r_k == 2'd2) ? S_DONE : S_DIV_GO;
      S_DONE:      if (w_release) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (r_state == S_IDLE);
    w_sqrt_start = (r_state == S_SQRT_GO);
    w_div_start  = (r_state == S_DIV_GO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_rad       <= '0;
      r_k         <= '0;
      r_mag       <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_nz        <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= w_cx;
            r_y    <= w_cy;
            r_z    <= w_cz;
            r_k    <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_SQUARE: begin
          r_rad <= w_rad;
          r_ovf <= w_sat;
          if (w_rad == 32'd0) begin
            r_zero <= 1'b1;
            r_mag  <= '0;
            r_nx   <= '0;
            r_ny   <= '0;
            r_nz   <= '0;
          end
        end
        S_SQRT_WAIT: begin
          if (w_sqrt_valid) begin
            r_mag <= {8'h00, w_root};
            r_k   <= '0;
          end
        end
        S_DIV_WAIT: begin
          if (w_div_done) begin
            case (r_k)
              2'd0:    r_nx <= w_div_valid ? w_div_val : 32'd0;
              2'd1:    r_ny <= w_div_valid ? w_div_val : 32'd0;
              default: r_nz <= w_div_valid ? w_div_val : 32'd0;
            endcase
            if (w_div_ovf || w_div_dbz) r_ovf <= 1'b1;
            r_k <= r_k + 2'd1;
          end
        end
        S_DONE: begin
          // Valid appears one cycle into DONE and drops on the accepting edge.
          r_out_valid <= !w_release;
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign nx          = r_nx;
  assign ny          = r_ny;
  assign nz          = r_nz;
  assign mag         = r_mag;
  assign zero_vec    = r_zero;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_vec_normalize.sv
// Bench for vec_normalize: directed vectors, backpressure, mid-run reset and random vectors,
// all compared against an arithmetic model of the normalisation.
`timescale 1ns/1ps
module tb_vec_normalize;
  localparam logic [2:0] ST_SQRT_WAIT = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x, y, z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] nx, ny, nz, mag;
  logic        zero_vec;
  logic        ovf;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [129:0] exp_q[$];

  vec_normalize #(.WIDTH(32), .FBITS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z           (z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .nx          (nx),
    .ny          (ny),
    .nz          (nz),
    .mag         (mag),
    .zero_vec    (zero_vec),
    .ovf         (ovf),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] clamp(input logic [31:0] v);
    return (v == 32'h8000_0000) ? 32'h8000_0001 : v;
  endfunction

  function automatic longint isqrt(input longint n);
    longint lo = 0;
    longint hi = 64'd33554432;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Round-half-even of a * 65536 / m with the sign of a.
  function automatic logic [31:0] quot(input logic [31:0] a, input longint m);
    longint av, num, q, r;
    bit neg;
    av  = longint'(signed'(a));
    neg = (av < 0);
    if (neg) av = -av;
    num = av * 65536;
    q = num / m;
    r = num % m;
    if ((2 * r > m) || ((2 * r == m) && (q % 2 == 1))) q = q + 1;
    if (neg) q = -q;
    return 32'(q);
  endfunction

  function automatic logic [129:0] model(input logic [31:0] vx, input logic [31:0] vy,
                                         input logic [31:0] vz);
    longint sx, sy, sz, sum, rad, m;
    bit sat;
    sx  = longint'(signed'(clamp(vx)));
    sy  = longint'(signed'(clamp(vy)));
    sz  = longint'(signed'(clamp(vz)));
    sum = (sx * sx) / 65536 + (sy * sy) / 65536 + (sz * sz) / 65536;
    sat = (sum > 64'h0000_0000_FFFF_FFFF);
    rad = sat ? 64'h0000_0000_FFFF_FFFF : sum;
    if (rad == 0) return {1'b1, 1'b0, 128'd0};
    m = isqrt(rad * 65536);
    return {1'b0, sat, 32'(m), quot(clamp(vx), m), quot(clamp(vy), m), quot(clamp(vz), m)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_vec(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] vz);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    x = vx;
    y = vy;
    z = vz;
    in_valid = 1'b1;
    exp_q.push_back(model(vx, vy, vz));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input bit early_ready, output int lat);
    logic [129:0] e;
    int t = 1;
    out_ready = early_ready;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    lat = t;
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_mag", mag, e[127:96]);
      check("hold_nx", nx, e[95:64]);
      @(negedge clk);
    end
    check("mag", mag, e[127:96]);
    check("nx", nx, e[95:64]);
    check("ny", ny, e[63:32]);
    check("nz", nz, e[31:0]);
    check("zero_vec", 32'(zero_vec), 32'(e[129]));
    check("ovf", 32'(ovf), 32'(e[128]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] dir_x[6];
    logic [31:0] dir_y[6];
    logic [31:0] dir_z[6];
    logic [31:0] comp[3];
    int lat;
    int highs;
    int hold;
    bit early;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    z = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mag", mag, 32'd0);
    check("rst_nx", nx, 32'd0);
    check("rst_ny", ny, 32'd0);
    check("rst_nz", nz, 32'd0);
    check("rst_zero_vec", 32'(zero_vec), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    dir_x = '{32'h0003_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0000_0000, 32'h012C_0000, 32'h8000_0000};
    dir_y = '{32'h0004_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    dir_z = '{32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      send_vec(dir_x[i], dir_y[i], dir_z[i]);
      get_result(0, 1'b0, lat);
      if (i == 3) check("zero_latency", 32'(lat), 32'd3);
    end

    // Backpressure on a (3, 4, 0) result.
    send_vec(32'h0003_0000, 32'h0004_0000, 32'h0000_0000);
    get_result(20, 1'b0, lat);

    // A second vector offered while busy must be ignored.
    send_vec(32'h0000_8000, 32'hFFFF_4000, 32'h0002_0000);
    x = 32'h0100_0000;
    y = 32'h0;
    z = 32'h0;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    get_result(1, 1'b0, lat);

    // Reset while the root is being computed.
    send_vec(32'h0005_0000, 32'h0006_0000, 32'h0007_0000);
    repeat (8) @(negedge clk);
    check("sqrt_wait_state", 32'(dbg_state), 32'(ST_SQRT_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    void'(exp_q.pop_back());
    highs = 0;
    for (int c = 0; c < 250; c++) begin
      if (out_valid) highs++;
      @(negedge clk);
    end
    check("abort_no_emit", 32'(highs), 32'd0);
    send_vec(32'h0003_0000, 32'h0004_0000, 32'h0000_0000);
    get_result(0, 1'b1, lat);

    // Random vectors over a spread of magnitudes.
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 5) == 0) comp[k] = 32'd0;
        else comp[k] = 32'($signed($urandom()) >>> $urandom_range(0, 15));
      end
      hold  = $urandom_range(0, 3);
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      send_vec(comp[0], comp[1], comp[2]);
      get_result(hold, early, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
